// File: rtl/qubo_demon_sched_if.sv
// Bundle between the demon scheduler, its control inputs and the shared energy/spin datapath.
// de_req/de_ack: de_req is held with de_idx stable until de_ack is sampled high on a rising edge; that edge captures de_val and completes the transfer.
interface qubo_demon_sched_if #(
  parameter int N_SPINS   = 8,
  parameter int E_W       = 8,
  parameter int MAX_COUNT = 1000
);
  localparam int IDX_W = $clog2(N_SPINS);
  localparam int CNT_W = $clog2(MAX_COUNT + 1);

  logic                    start;
  logic [E_W-1:0]          demon_init;
  logic                    de_req;
  logic [IDX_W-1:0]        de_idx;
  logic                    de_ack;
  logic signed [E_W:0]     de_val;
  logic                    flip;
  logic [IDX_W-1:0]        flip_idx;
  logic [E_W-1:0]          demon_energy;
  logic [CNT_W-1:0]        sweep_count;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, demon_init, de_ack, de_val,
    output de_req, de_idx, flip, flip_idx, demon_energy, sweep_count, busy, done
  );

  modport slave (
    output start, demon_init, de_ack, de_val,
    input  de_req, de_idx, flip, flip_idx, demon_energy, sweep_count, busy, done
  );
endinterface

// File: rtl/qubo_demon_sched.sv
// Creutz-demon sweep controller: requests dE per spin, applies the demon acceptance rule,
// tracks demon energy with saturation and stops after MAX_COUNT sweeps.
module qubo_demon_sched #(
  parameter int N_SPINS   = 8,
  parameter int E_W       = 8,
  parameter int MAX_COUNT = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  qubo_demon_sched_if.master bus,
  output logic [1:0]         state_o
);
  localparam int IDX_W = $clog2(N_SPINS);
  localparam int CNT_W = $clog2(MAX_COUNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SPINS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(MAX_COUNT - 1);
  localparam logic [E_W-1:0]   DEMON_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [E_W-1:0]        demon_q, demon_d;
  logic signed [E_W:0]   dv_q, dv_d;

  logic                  accept;
  logic signed [E_W+1:0] diff;
  logic                  sat;

  // Demon is zero-extended so that every negative dE is accepted.
  assign accept = dv_q <= $signed({1'b0, demon_q});
  assign diff   = $signed({2'b00, demon_q}) - $signed({dv_q[E_W], dv_q});
  assign sat    = diff > $signed({2'b00, DEMON_MAX});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      demon_q <= '0;
      dv_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      demon_q <= demon_d;
      dv_q    <= dv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    demon_d = demon_q;
    dv_d    = dv_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          demon_d = bus.demon_init;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.de_ack) begin
          dv_d    = bus.de_val;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (accept) demon_d = sat ? DEMON_MAX : diff[E_W-1:0];
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_REQ;
        end else begin
          idx_d   = '0;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == LAST_CNT) ? S_DONE : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.de_req       = (state_q == S_REQ);
    bus.de_idx       = idx_q;
    bus.flip         = (state_q == S_EVAL) && accept;
    bus.flip_idx     = bus.flip ? idx_q : '0;
    bus.demon_energy = demon_q;
    bus.sweep_count  = cnt_q;
    bus.busy         = (state_q == S_REQ) || (state_q == S_EVAL);
    bus.done         = (state_q == S_DONE);
    state_o          = state_q;
  end
endmodule

// File: doc/qubo_demon_sched.md
# qubo_demon_sched

Sequencing controller for the QUBO demon annealer. It walks the spin index through repeated sweeps and requests the energy change of each candidate flip from the energy datapath over a req/ack handshake. It applies the Creutz demon acceptance rule, tracks the demon energy, and issues flip pulses to the spin register. It sits between the top-level control inputs (start, demon seed) and the shared energy/spin datapath, and stops after a fixed number of sweeps.

## Interface
- `N_SPINS`, 8: number of spins per sweep; ≥2, power of two not required.
- `E_W`, 8: demon energy width, unsigned.
- `MAX_COUNT`, 1000: number of sweeps per run; ≥1.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `demon_init` in E_W: demon energy loaded on accepted start.
- `de_req` out 1: request for the ΔE of flipping spin `de_idx`.
- `de_idx` out clog2(N_SPINS): spin under evaluation; held stable while `de_req`=1.
- `de_ack` in 1: datapath response; qualifies `de_val`.
- `de_val` in E_W+1: signed two's-complement ΔE of flipping `de_idx`.
- `flip` out 1: one-cycle pulse commanding a flip of spin `flip_idx`.
- `flip_idx` out clog2(N_SPINS): equals the evaluated index during the `flip` cycle.
- `demon_energy` out E_W: current demon energy.
- `sweep_count` out clog2(MAX_COUNT+1): completed sweeps in the current run.
- `busy` out 1: high in REQ and EVAL.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, REQ, EVAL, DONE.
- **IDLE/DONE:**
  - On `start`=1: load `demon_energy`←`demon_init`, `de_idx`←0, `sweep_count`←0, `done`←0; go to REQ.
- **REQ:**
  - `de_req`=1.
  - On `de_ack`=1, capture `de_val` into an internal register, drop `de_req` and go to EVAL.
  - Otherwise remain in REQ indefinitely; there is no timeout.
- **EVAL** (exactly one cycle). Acceptance rule: accept iff `de_val` ≤ `demon_energy`, compared as signed with the demon zero-extended.
  - ΔE=0 is accepted.
  - Any negative ΔE is accepted.
- On accept:
  - `flip`=1 and `flip_idx`=`de_idx` this cycle.
  - `demon_energy`←`demon_energy`−ΔE, computed at E_W+2 bits signed.
  - If the result exceeds 2^E_W−1, saturate to 2^E_W−1. The result can never go negative under the acceptance rule.
- On reject: no `flip`, demon unchanged.
- Index advance at the end of EVAL:
  - If `de_idx`<N_SPINS−1: `de_idx`+1, go to REQ.
  - Else `de_idx`←0 and `sweep_count`+1. If the new count equals MAX_COUNT, go to DONE; otherwise go to REQ.
- **DONE:** `done`=1. `demon_energy` and `sweep_count` are held until the next accepted start.
- `start` in REQ/EVAL is ignored.
- `de_ack` outside REQ is ignored, and `de_val` is not captured.
- `rst_n` low at any time:
  - Immediately (asynchronously) return to IDLE.
  - Aborts any run; no further `flip`; pending request dropped.

## Timing
- Reset values: `de_req`=0, `de_idx`=0, `flip`=0, `flip_idx`=0, `demon_energy`=0, `sweep_count`=0, `busy`=0, `done`=0; state IDLE.
- `start` sampled high in IDLE at edge t: state is REQ and `de_req`=1 after edge t (visible in cycle t+1).
- Ack sampled at edge a: EVAL during cycle a+1.
  - `flip` is high in cycle a+1.
  - The updated `demon_energy` is visible after edge a+1.
  - `de_req` re-asserts for the next index in cycle a+2.
- Zero-wait datapath (ack in the first REQ cycle): 2 cycles per spin, 2·N_SPINS cycles per sweep.
- Last spin of the last sweep: `done`=1 and `busy`=0 from the cycle after EVAL. `sweep_count`=MAX_COUNT in the same cycle.
- `flip` is never high in two consecutive cycles.
- `de_req` and `flip` are never high together.

## Test plan
- **Reset:**
  - Stimulus: drive `rst_n`=0 mid-REQ with `de_req`=1.
  - Response: all outputs take reset values asynchronously; after release, no activity until `start`.
- **Accept/reject:**
  - Stimulus: `demon_init`=5; ΔE sequence +3, +4, −2, 0.
  - Response: flips on spins 0, 2, 3, not on 1. Demon goes 5→2→2→4→4.
- **Saturation:**
  - Stimulus: E_W=8, `demon_init`=250, ΔE=−20.
  - Response: accepted with `flip` asserted; `demon_energy`=255.
- **Run length:**
  - Stimulus: N_SPINS=4, MAX_COUNT=3, zero-wait ack, all ΔE=+1, `demon_init`=0.
  - Response: no flips.
  - Response: `done` rises exactly 24 cycles after the first REQ cycle, with `sweep_count`=3 and `de_idx`=0.
- **Handshake stall:**
  - Stimulus: withhold `de_ack` for 10 cycles.
  - Response: `de_req` and `de_idx` are held stable throughout.
  - Response: a spurious `de_ack` pulse during EVAL or DONE is ignored.
- **Start rules:**
  - Stimulus: `start` during a run.
  - Response: no effect.
  - Stimulus: `start` in DONE.
  - Response: demon reloaded, `sweep_count`=0, `done`=0 on the next cycle.
